// File: rtl/sne_stream_tx.sv
// Packetizing uDMA stream transmitter: buffers engine event words in a FIFO and
// frames them into SOT/EOT-delimited packets closed by word count or flush.
module sne_stream_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic [LEN_WIDTH-1:0]        pkt_len_i,
  input  logic                        flush_i,
  input  logic                        evt_valid_i,
  output logic                        evt_ready_o,
  input  logic [DATA_WIDTH-1:0]       evt_data_i,
  output logic [DATA_WIDTH-1:0]       udma_stream_data_o,
  output logic [1:0]                  udma_stream_datasize_o,
  output logic                        udma_stream_valid_o,
  output logic                        udma_stream_sot_o,
  output logic                        udma_stream_eot_o,
  input  logic                        udma_stream_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        pkt_done_o,
  output logic                        busy_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // state     | meaning
  // ST_STREAM | present the FIFO head as stream data
  // ST_TERM   | present a zero terminator word with EOT to close an empty open packet
  typedef enum logic {ST_STREAM, ST_TERM} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  pkt_open_q, pkt_open_d;
  logic [LEN_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CW-1:0]         flush_cnt_q, flush_cnt_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  pkt_done_q, pkt_done_d;

  logic                  push, pop, hs, term_hs;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [CW-1:0]         count_post;

  always_comb begin
    evt_ready_o = rst_ni & enable_i & (count_q != DEPTH_C);
    push        = evt_valid_i & evt_ready_o;

    // The SOT word has no latched length yet, so it uses the live one.
    if (pkt_open_q) begin
      cur_len = len_q;
    end else if (pkt_len_i == '0) begin
      cur_len = LEN_WIDTH'(1);
    end else begin
      cur_len = pkt_len_i;
    end

    udma_stream_valid_o = 1'b0;
    udma_stream_sot_o   = 1'b0;
    udma_stream_eot_o   = 1'b0;
    udma_stream_data_o  = '0;
    if (state_q == ST_TERM) begin
      udma_stream_valid_o = 1'b1;
      udma_stream_eot_o   = 1'b1;
    end else if (count_q != '0) begin
      udma_stream_valid_o = 1'b1;
      udma_stream_data_o  = mem_q[rd_ptr_q];
      udma_stream_sot_o   = ~pkt_open_q;
      udma_stream_eot_o   = (wcnt_q == cur_len - LEN_WIDTH'(1)) |
                            (flush_pend_q & (flush_cnt_q == CW'(1)));
    end

    hs         = udma_stream_valid_o & udma_stream_ready_i;
    pop        = hs & (state_q == ST_STREAM);
    term_hs    = hs & (state_q == ST_TERM);
    count_post = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = evt_data_i;
    end
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_post;
    state_d      = state_q;
    pkt_open_d   = pkt_open_q;
    wcnt_d       = wcnt_q;
    len_d        = len_q;
    flush_cnt_d  = flush_cnt_q;
    flush_pend_d = flush_pend_q;
    pkt_done_d   = hs & udma_stream_eot_o;

    if (pop) begin
      if (!pkt_open_q) begin
        len_d = cur_len;
      end
      if (udma_stream_eot_o) begin
        pkt_open_d = 1'b0;
        wcnt_d     = '0;
      end else begin
        pkt_open_d = 1'b1;
        wcnt_d     = wcnt_q + LEN_WIDTH'(1);
      end
      if (flush_pend_q) begin
        if (flush_cnt_q == CW'(1)) begin
          flush_pend_d = 1'b0;
        end
        flush_cnt_d = flush_cnt_q - CW'(1);
      end
    end

    if (term_hs) begin
      state_d      = ST_STREAM;
      pkt_open_d   = 1'b0;
      wcnt_d       = '0;
      flush_pend_d = 1'b0;
    end

    // The flush mark is the last word buffered after this cycle's push/pop.
    if (flush_i && !flush_pend_q) begin
      if (count_post != '0) begin
        flush_pend_d = 1'b1;
        flush_cnt_d  = count_post;
      end else if (pkt_open_d) begin
        flush_pend_d = 1'b1;
        flush_cnt_d  = '0;
        state_d      = ST_TERM;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_STREAM;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_open_q   <= 1'b0;
      wcnt_q       <= '0;
      len_q        <= '0;
      flush_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pkt_open_q   <= pkt_open_d;
      wcnt_q       <= wcnt_d;
      len_q        <= len_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_pend_q <= flush_pend_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign udma_stream_datasize_o = 2'b10;
  assign fifo_count_o           = count_q;
  assign pkt_done_o             = pkt_done_q;
  assign busy_o                 = (count_q != '0) | pkt_open_q | flush_pend_q;

endmodule

// File: tb/tb_sne_stream_tx.sv
// Scoreboard bench for sne_stream_tx: a packet-framing model queues expected
// stream words as events are pushed; a negedge monitor pops and compares.
module tb_sne_stream_tx;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          enable;
  logic [LW-1:0] pkt_len;
  logic          flush;
  logic          evt_valid;
  logic          evt_ready_o;
  logic [DW-1:0] evt_data;
  logic [DW-1:0] s_data;
  logic [1:0]    s_size;
  logic          s_valid, s_sot, s_eot;
  logic          s_ready;
  logic [3:0]    fifo_count_o;
  logic          pkt_done_o, busy_o;

  always #5 clk = ~clk;

  sne_stream_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_ni),
    .enable_i               (enable),
    .pkt_len_i              (pkt_len),
    .flush_i                (flush),
    .evt_valid_i            (evt_valid),
    .evt_ready_o            (evt_ready_o),
    .evt_data_i             (evt_data),
    .udma_stream_data_o     (s_data),
    .udma_stream_datasize_o (s_size),
    .udma_stream_valid_o    (s_valid),
    .udma_stream_sot_o      (s_sot),
    .udma_stream_eot_o      (s_eot),
    .udma_stream_ready_i    (s_ready),
    .fifo_count_o           (fifo_count_o),
    .pkt_done_o             (pkt_done_o),
    .busy_o                 (busy_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    bit            sot;
    bit            eot;
    bit            term;
    bit            mark;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pos = 0;
  int   cur_len = 1;
  bit   mon_open = 1'b0;
  bit   mon_en = 1'b0;
  int   done_cnt = 0;
  bit   prev_eot = 1'b0;
  bit   stalled = 1'b0;
  logic [DW-1:0] h_data;
  bit   h_sot;
  exp_t me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int data_count();
    int n = 0;
    foreach (exp_q[i]) if (!exp_q[i].term) n++;
    return n;
  endfunction

  function automatic bit pending();
    foreach (exp_q[i]) if (exp_q[i].mark) return 1'b1;
    return 1'b0;
  endfunction

  // Packet framing from the word sequence: position in packet and length latched at packet start.
  task automatic model_push(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.term = 1'b0;
    e.mark = 1'b0;
    e.sot  = (pos == 0);
    if (e.sot) cur_len = (pkt_len == '0) ? 1 : int'(pkt_len);
    e.eot  = (pos == cur_len - 1);
    pos    = e.eot ? 0 : pos + 1;
    exp_q.push_back(e);
  endtask

  task automatic model_flush();
    exp_t e;
    if (data_count() > 0) begin
      e = exp_q.pop_back();
      e.eot  = 1'b1;
      e.mark = 1'b1;
      exp_q.push_back(e);
      pos = 0;
    end else if (pos != 0) begin
      e.data = '0;
      e.sot  = 1'b0;
      e.eot  = 1'b1;
      e.term = 1'b1;
      e.mark = 1'b1;
      exp_q.push_back(e);
      pos = 0;
    end
  endtask

  // Entered and left at posedge+1; inputs are already driven by the caller.
  task automatic step(output bit pushed);
    int occ;
    bit pend, open0, exp_rdy;
    occ     = data_count();
    pend    = pending();
    open0   = mon_open;
    exp_rdy = enable && (occ < DEPTH);
    @(negedge clk);
    #1;
    chk("evt_ready", 32'(evt_ready_o), 32'(exp_rdy));
    chk("fifo_count", 32'(fifo_count_o), 32'(occ));
    chk("busy", 32'(busy_o), 32'((occ != 0) || open0 || pend));
    pushed = evt_valid && exp_rdy;
    if (pushed) model_push(evt_data);
    if (flush && !pend) model_flush();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input bit fl);
    bit p = 1'b0;
    int n = 0;
    evt_valid = 1'b1;
    evt_data  = d;
    flush     = fl;
    while (!p && n < 200) begin
      step(p);
      flush = 1'b0;
      n++;
    end
    if (!p) begin
      errors++;
      $display("FAIL push_timeout: word %0h not accepted, required acceptance", d);
    end
    evt_valid = 1'b0;
  endtask

  task automatic do_flush();
    bit p;
    evt_valid = 1'b0;
    flush = 1'b1;
    step(p);
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    bit p;
    evt_valid = 1'b0;
    for (int i = 0; i < n; i++) step(p);
  endtask

  task automatic drain();
    bit p;
    int n = 0;
    evt_valid = 1'b0;
    flush = 1'b0;
    s_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      step(p);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: actual=%0d words left required=0", exp_q.size());
      exp_q.delete();
    end
    step(p);
  endtask

  task automatic chk_reset();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_sot", 32'(s_sot), 32'd0);
    chk("rst_eot", 32'(s_eot), 32'd0);
    chk("rst_data", s_data, 32'd0);
    chk("rst_count", 32'(fifo_count_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(pkt_done_o), 32'd0);
    chk("rst_datasize", 32'(s_size), 32'd2);
  endtask

  always @(negedge clk) begin
    if (!rst_ni || !mon_en) begin
      prev_eot = 1'b0;
      stalled  = 1'b0;
    end else begin
      chk("pkt_done", 32'(pkt_done_o), 32'(prev_eot));
      if (pkt_done_o) done_cnt++;
      if (stalled) begin
        chk("stall_valid", 32'(s_valid), 32'd1);
        chk("stall_data", s_data, h_data);
        chk("stall_sot", 32'(s_sot), 32'(h_sot));
      end
      if (!s_valid) chk("idle_data", s_data, 32'd0);
      if (s_valid && s_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: actual data=%0h required no word", s_data);
        end else begin
          me = exp_q.pop_front();
          chk("out_data", s_data, me.data);
          chk("out_sot", 32'(s_sot), 32'(me.sot));
          chk("out_eot", 32'(s_eot), 32'(me.eot));
          mon_open = me.term ? 1'b0 : !me.eot;
        end
        prev_eot = s_eot;
        stalled  = 1'b0;
      end else begin
        prev_eot = 1'b0;
        stalled  = s_valid;
        h_data   = s_data;
        h_sot    = s_sot;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit p;
    rst_ni = 1'b0; enable = 1'b1; pkt_len = 16'd4; flush = 1'b0;
    evt_valid = 1'b0; evt_data = '0; s_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_evt_ready", 32'(evt_ready_o), 32'd0);
    chk_reset();
    rst_ni = 1'b1;
    mon_en = 1'b1;

    // Fixed-length packets of 4
    d0 = done_cnt;
    push_word(32'd1, 1'b0);
    chk("first_latency_valid", 32'(s_valid), 32'd1);
    chk("first_latency_data", s_data, 32'd1);
    for (int i = 2; i <= 8; i++) push_word(32'(i), 1'b0);
    drain();
    chk("fixed_len_done_pulses", 32'(done_cnt - d0), 32'd2);

    // Backpressure: nine words into depth 8 with the sink stalled
    pkt_len = 16'd3;
    s_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i), 1'b0);
    evt_valid = 1'b1;
    evt_data  = 32'h108;
    for (int i = 0; i < 3; i++) step(p);
    chk("full_count", 32'(fifo_count_o), 32'd8);
    s_ready = 1'b1;
    push_word(32'h108, 1'b0);
    drain();

    // Flush in the cycle D is pushed, then E opens a new packet
    pkt_len = 16'd16;
    push_word(32'hA, 1'b0);
    push_word(32'hB, 1'b0);
    push_word(32'hC, 1'b0);
    push_word(32'hD, 1'b1);
    push_word(32'hE, 1'b0);
    drain();
    do_flush();
    drain();

    // Flush on an empty open packet, then on no packet
    push_word(32'h21, 1'b0);
    push_word(32'h22, 1'b0);
    drain();
    d0 = done_cnt;
    do_flush();
    drain();
    chk("term_done_pulses", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt;
    do_flush();
    idle(5);
    chk("idle_flush_no_done", 32'(done_cnt - d0), 32'd0);

    // Edge lengths and mid-packet length change
    pkt_len = 16'd0;
    for (int i = 0; i < 3; i++) push_word(32'h30 + 32'(i), 1'b0);
    drain();
    pkt_len = 16'd1;
    for (int i = 0; i < 3; i++) push_word(32'h40 + 32'(i), 1'b0);
    drain();
    pkt_len = 16'd4;
    push_word(32'h50, 1'b0);
    push_word(32'h51, 1'b0);
    drain();
    pkt_len = 16'd2;
    for (int i = 2; i < 8; i++) push_word(32'h50 + 32'(i), 1'b0);
    drain();

    // Randomized traffic with backpressure, enable gaps and flushes
    for (int s = 0; s < 3; s++) begin
      pkt_len = 16'($urandom_range(0, 5));
      for (int c = 0; c < 300; c++) begin
        enable    = ($urandom_range(0, 99) < 85);
        s_ready   = ($urandom_range(0, 99) < 70);
        evt_valid = ($urandom_range(0, 99) < 60);
        evt_data  = $urandom();
        flush     = ($urandom_range(0, 99) < 4);
        step(p);
      end
      enable = 1'b1;
      drain();
      do_flush();
      drain();
    end

    // Reset mid-packet with three words buffered
    pkt_len = 16'd16;
    s_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'h70 + 32'(i), 1'b0);
    rst_ni    = 1'b0;
    evt_valid = 1'b1;
    evt_data  = 32'h7F;
    @(negedge clk);
    #1;
    chk("evt_ready_in_reset", 32'(evt_ready_o), 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    pos = 0;
    mon_open = 1'b0;
    chk_reset();
    rst_ni = 1'b1;
    evt_valid = 1'b0;
    s_ready = 1'b1;
    push_word(32'h80, 1'b0);
    chk("post_reset_sot", 32'(s_sot), 32'd1);
    drain();
    do_flush();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
